mat_mult_2x2_fsm_pipe: RTL and testbench



---
 rtl/mat_mult_pkg.sv | 26 ++
 rtl/mat_mult_2x2_fsm_pipe_dot2_pipe.sv | 57 +++++
 rtl/mat_mult_2x2_fsm_pipe.sv | 110 +++++++++++
 tb/tb_mat_mult_2x2_fsm_pipe.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mat_mult_pkg.sv
// Shared constants, types and helpers for the 2x2 signed matrix multiplier.
package mat_mult_pkg;

  localparam int DATA_W = 16;
  localparam int RES_W  = 32;

  typedef logic signed [DATA_W-1:0] operand_t;
  typedef logic signed [RES_W-1:0]  result_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } occ_state_t;

  // Full-width signed product; both operands are sign-extended before multiplying.
  function automatic result_t mul_full(input operand_t p, input operand_t q);
    result_t p_ext;
    result_t q_ext;
    p_ext = result_t'(p);
    q_ext = result_t'(q);
    return p_ext * q_ext;
  endfunction

endpackage

// File: rtl/mat_mult_2x2_fsm_pipe_dot2_pipe.sv
// Two-term signed dot product p*q + r*s with a product stage and a sum stage.
module dot2_pipe
  import mat_mult_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  input  operand_t   p,
  input  operand_t   q,
  input  operand_t   r,
  input  operand_t   s,
  output result_t    sum,
  output logic [1:0] stage_valid
);

  result_t                prod_pq_r;
  result_t                prod_rs_r;
  logic                   prod_valid_r;
  logic                   sum_valid_r;
  logic signed [RES_W:0]  sum_wide_s;

  // Product stage: registers both products when the incoming item is valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_pq_r    <= '0;
      prod_rs_r    <= '0;
      prod_valid_r <= 1'b0;
    end else begin
      prod_valid_r <= valid_in;
      if (valid_in) begin
        prod_pq_r <= mul_full(p, q);
        prod_rs_r <= mul_full(r, s);
      end
    end
  end

  // One guard bit of headroom; only +2^31 can overflow and it wraps on truncation.
  always_comb begin
    sum_wide_s = {prod_pq_r[RES_W-1], prod_pq_r} + {prod_rs_r[RES_W-1], prod_rs_r};
  end

  // Sum stage: result holds its last value across bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum         <= '0;
      sum_valid_r <= 1'b0;
    end else begin
      sum_valid_r <= prod_valid_r;
      if (prod_valid_r) begin
        sum <= result_t'(sum_wide_s[RES_W-1:0]);
      end
    end
  end

  assign stage_valid = {sum_valid_r, prod_valid_r};

endmodule

// File: rtl/mat_mult_2x2_fsm_pipe.sv
// Three-stage pipelined 2x2 signed matrix multiplier with an occupancy FSM for debug.
module mat_mult_2x2_fsm_pipe
  import mat_mult_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     start,
  input  operand_t a,
  input  operand_t b,
  input  operand_t c,
  input  operand_t d,
  input  operand_t e,
  input  operand_t f,
  input  operand_t g,
  input  operand_t h,
  output result_t  w,
  output result_t  x,
  output result_t  y,
  output result_t  z,
  output logic     done
);

  operand_t   a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r;
  logic       v1_r;
  logic [1:0] sv_w_s, sv_x_s, sv_y_s, sv_z_s;
  logic       v2_s;
  logic       v3_s;
  occ_state_t state_r;
  occ_state_t state_next_s;

  // S1: operand capture, only on accepted items.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r  <= '0;
      b_r  <= '0;
      c_r  <= '0;
      d_r  <= '0;
      e_r  <= '0;
      f_r  <= '0;
      g_r  <= '0;
      h_r  <= '0;
      v1_r <= 1'b0;
    end else begin
      v1_r <= start;
      if (start) begin
        a_r <= a;
        b_r <= b;
        c_r <= c;
        d_r <= d;
        e_r <= e;
        f_r <= f;
        g_r <= g;
        h_r <= h;
      end
    end
  end

  dot2_pipe u_dot_w (.clk(clk), .reset(reset), .valid_in(v1_r),
                     .p(a_r), .q(e_r), .r(b_r), .s(g_r), .sum(w), .stage_valid(sv_w_s));
  dot2_pipe u_dot_x (.clk(clk), .reset(reset), .valid_in(v1_r),
                     .p(a_r), .q(f_r), .r(b_r), .s(h_r), .sum(x), .stage_valid(sv_x_s));
  dot2_pipe u_dot_y (.clk(clk), .reset(reset), .valid_in(v1_r),
                     .p(c_r), .q(e_r), .r(d_r), .s(g_r), .sum(y), .stage_valid(sv_y_s));
  dot2_pipe u_dot_z (.clk(clk), .reset(reset), .valid_in(v1_r),
                     .p(c_r), .q(f_r), .r(d_r), .s(h_r), .sum(z), .stage_valid(sv_z_s));

  // The four lanes share one valid chain, so their stage bits are identical.
  assign v2_s = sv_w_s[0] | sv_x_s[0] | sv_y_s[0] | sv_z_s[0];
  assign v3_s = sv_w_s[1] | sv_x_s[1] | sv_y_s[1] | sv_z_s[1];
  assign done = sv_w_s[1];

  // Occupancy next state, judged on the valid bits as they will be after this edge.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = FILL;
        else       state_next_s = IDLE;
      end
      FILL: begin
        if (v2_s)                state_next_s = STREAM;
        else if (start || v1_r)  state_next_s = FILL;
        else                     state_next_s = IDLE;
      end
      STREAM: begin
        if (!start && (v1_r || v2_s)) state_next_s = DRAIN;
        else if (!start)              state_next_s = IDLE;
        else if (v2_s)                state_next_s = STREAM;
        else                          state_next_s = FILL;
      end
      DRAIN: begin
        if (start && v2_s)       state_next_s = STREAM;
        else if (start)          state_next_s = FILL;
        else if (v1_r || v2_s)   state_next_s = DRAIN;
        else                     state_next_s = IDLE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Occupancy state register; observational only, never gates data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

endmodule

// File: tb/tb_mat_mult_2x2_fsm_pipe.sv
// Self-checking bench: directed vectors plus random streams against a queue-based reference.
module tb_mat_mult_2x2_fsm_pipe;
  import mat_mult_pkg::*;

  logic     clk;
  logic     reset;
  logic     start;
  operand_t a, b, c, d, e, f, g, h;
  result_t  w, x, y, z;
  logic     done;

  int checks;
  int errors;

  typedef struct {
    bit v;
    int rw;
    int rx;
    int ry;
    int rz;
  } item_t;

  item_t hist[$];
  int    mw, mx, my, mz;
  bit    mdone;

  mat_mult_2x2_fsm_pipe dut (
    .clk(clk), .reset(reset), .start(start),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .w(w), .x(x), .y(y), .z(z), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  function automatic int dot(input int p, input int q, input int r, input int s);
    longint t;
    logic [63:0] tb;
    t  = longint'(p) * longint'(q) + longint'(r) * longint'(s);
    tb = t;
    return int'(tb[31:0]);
  endfunction

  task automatic model_clear();
    hist.delete();
    mw = 0; mx = 0; my = 0; mz = 0;
    mdone = 1'b0;
  endtask

  // One clock: drive, take the edge, advance the model, compare all outputs.
  task automatic cycle(input bit st, input int op[8], input string tag);
    item_t it;
    start = st;
    a = operand_t'(op[0]); b = operand_t'(op[1]); c = operand_t'(op[2]); d = operand_t'(op[3]);
    e = operand_t'(op[4]); f = operand_t'(op[5]); g = operand_t'(op[6]); h = operand_t'(op[7]);
    @(posedge clk);
    it.v  = st;
    it.rw = dot(op[0], op[4], op[1], op[6]);
    it.rx = dot(op[0], op[5], op[1], op[7]);
    it.ry = dot(op[2], op[4], op[3], op[6]);
    it.rz = dot(op[2], op[5], op[3], op[7]);
    hist.push_back(it);
    if (hist.size() > 3) void'(hist.pop_front());
    mdone = 1'b0;
    if (hist.size() == 3 && hist[0].v) begin
      mdone = 1'b1;
      mw = hist[0].rw; mx = hist[0].rx; my = hist[0].ry; mz = hist[0].rz;
    end
    #1;
    check_eq({tag, "_done"}, {31'd0, done}, {31'd0, mdone});
    check_eq({tag, "_w"}, w, mw);
    check_eq({tag, "_x"}, x, mx);
    check_eq({tag, "_y"}, y, my);
    check_eq({tag, "_z"}, z, mz);
  endtask

  task automatic rand_ops(input int lo, input int hi, output int op[8]);
    for (int i = 0; i < 8; i++) op[i] = lo + int'($urandom_range(hi - lo, 0));
  endtask

  initial begin
    int op[8];
    int junk[8];
    bit pat[5];
    checks = 0;
    errors = 0;
    model_clear();
    reset = 1'b1;
    start = 1'b0;
    {a, b, c, d, e, f, g, h} = '0;
    #1;
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_w", w, 32'd0);
    check_eq("rst_z", z, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single item, then hold.
    op = '{1, 2, 3, 4, 5, 6, 7, 8};
    cycle(1'b1, op, "single");
    rand_ops(-32768, 32767, junk);
    cycle(1'b0, junk, "single");
    rand_ops(-32768, 32767, junk);
    cycle(1'b0, junk, "single");
    check_eq("single_w_const", w, 32'sd19);
    check_eq("single_x_const", x, 32'sd22);
    check_eq("single_y_const", y, 32'sd43);
    check_eq("single_z_const", z, 32'sd50);
    check_eq("single_done_const", {31'd0, done}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      rand_ops(-32768, 32767, junk);
      cycle(1'b0, junk, "hold");
    end
    check_eq("hold_w_const", w, 32'sd19);

    // Signs.
    op = '{-20, 20, -1, 0, 20, -20, 20, 7};
    cycle(1'b1, op, "signs");
    for (int i = 0; i < 2; i++) begin
      rand_ops(-32768, 32767, junk);
      cycle(1'b0, junk, "signs");
    end
    check_eq("signs_w_const", w, 32'sd0);
    check_eq("signs_x_const", x, 32'sd540);
    check_eq("signs_y_const", y, -32'sd20);
    check_eq("signs_z_const", z, 32'sd20);

    // Overflow wrap.
    op = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
    cycle(1'b1, op, "ovf");
    for (int i = 0; i < 2; i++) cycle(1'b0, op, "ovf");
    check_eq("ovf_w_const", w, 32'h8000_0000);
    check_eq("ovf_z_const", z, 32'h8000_0000);

    // Bubbles 1,0,1,1,0.
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rand_ops(-20, 20, op);
      cycle(pat[i], op, "bubble");
    end
    for (int i = 0; i < 3; i++) begin
      rand_ops(-32768, 32767, junk);
      cycle(1'b0, junk, "bubble_tail");
    end

    // 100 back-to-back items.
    for (int i = 0; i < 100; i++) begin
      rand_ops(-20, 20, op);
      cycle(1'b1, op, "stream");
    end
    for (int i = 0; i < 3; i++) begin
      rand_ops(-20, 20, junk);
      cycle(1'b0, junk, "stream_tail");
    end

    // Full-range random with random start.
    for (int i = 0; i < 60; i++) begin
      rand_ops(-32768, 32767, op);
      cycle(1'($urandom_range(1, 0)), op, "rand");
    end

    // Reset with two items in flight.
    rand_ops(-20, 20, op);
    cycle(1'b1, op, "pre_rst");
    rand_ops(-20, 20, op);
    cycle(1'b1, op, "pre_rst");
    #2;
    reset = 1'b1;
    #1;
    check_eq("midrst_done", {31'd0, done}, 32'd0);
    check_eq("midrst_w", w, 32'd0);
    check_eq("midrst_x", x, 32'd0);
    check_eq("midrst_y", y, 32'd0);
    check_eq("midrst_z", z, 32'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_ops(-32768, 32767, junk);
      cycle(1'b0, junk, "post_rst_idle");
    end
    op = '{1, 2, 3, 4, 5, 6, 7, 8};
    cycle(1'b1, op, "post_rst");
    for (int i = 0; i < 2; i++) begin
      rand_ops(-32768, 32767, junk);
      cycle(1'b0, junk, "post_rst");
    end
    check_eq("post_rst_w_const", w, 32'sd19);
    check_eq("post_rst_z_const", z, 32'sd50);
    rand_ops(-32768, 32767, junk);
    cycle(1'b0, junk, "post_rst_hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
